i2c_bus_arbiter: RTL and testbench

Two-client arbiter that shares the single byte-level I2C master between two requesters, e.g. the BMP180 sequencer and a second sensor or configuration engine. It sits between the clients and the master's start/send/receive handshake. It grants the whole bus to one client per transaction with round-robin fairness, and muxes handshake signals and data to the owner. A watchdog revokes ownership from a client that stalls the bus.

---
 rtl/i2c_bus_arbiter_if.sv | 55 +++++
 rtl/i2c_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// ============================================================================
// Module      : i2c_bus_arbiter_if
// Description : Client-side and master-side handshake bundle of the
//               two-client I2C bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_bus_arbiter_if;
    // Client 0 / client 1 side
    logic       req0, req1;
    logic       gnt0, gnt1;
    logic       start0, start1;
    logic       send0, send1;
    logic       receive0, receive1;
    logic [7:0] datasend0, datasend1;
    logic       ready0, ready1;
    logic       sended0, sended1;
    logic       received0, received1;
    logic [7:0] datareceive0, datareceive1;

    // Byte-level I2C master side
    logic       start, send, receive;
    logic [7:0] datasend;
    logic       ready, sended, received;
    logic [7:0] datareceive;

    // Arbitration status
    logic       owner;
    logic       timeout;

    // Arbiter view
    modport slave (
        input  req0, req1, start0, start1, send0, send1, receive0, receive1,
        input  datasend0, datasend1,
        input  ready, sended, received, datareceive,
        output gnt0, gnt1, ready0, ready1, sended0, sended1,
        output received0, received1, datareceive0, datareceive1,
        output start, send, receive, datasend,
        output owner, timeout
    );

    // Environment view: clients plus the byte-level master
    modport master (
        output req0, req1, start0, start1, send0, send1, receive0, receive1,
        output datasend0, datasend1,
        output ready, sended, received, datareceive,
        input  gnt0, gnt1, ready0, ready1, sended0, sended1,
        input  received0, received1, datareceive0, datareceive1,
        input  start, send, receive, datasend,
        input  owner, timeout
    );
endinterface

`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
// ============================================================================
// Module      : i2c_bus_arbiter
// Description : Round-robin two-client arbiter in front of a byte-level I2C
//               master, with a stall watchdog that revokes the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_arbiter #(
    parameter int TIMEOUT = 1000000,
    parameter int TW      = 20
) (
    input  wire              clk,
    input  wire              reset,
    i2c_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN0    = 2'd1,
        S_OWN1    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam bit          C_WD_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] C_LIMIT = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        r_state;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_owner;
    logic          r_timeout;
    logic          r_elig0;
    logic          r_elig1;
    logic [TW-1:0] r_cnt;

    logic w_e0;
    logic w_e1;
    logic w_any;
    logic w_pick1;
    logic w_own_req;
    logic w_act;
    logic w_expire;

    // Both eligible: the client that did not own the bus last time wins
    assign w_e0      = bus.req0 & r_elig0;
    assign w_e1      = bus.req1 & r_elig1;
    assign w_any     = w_e0 | w_e1;
    assign w_pick1   = w_e1 & (~w_e0 | ~r_owner);
    assign w_own_req = (r_state == S_OWN1) ? bus.req1 : bus.req0;
    assign w_act     = bus.start | bus.send | bus.receive | bus.sended | bus.received;
    assign w_expire  = C_WD_EN && (r_cnt == C_LIMIT) && !w_act;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_owner   <= 1'b1;
            r_timeout <= 1'b0;
            r_elig0   <= 1'b1;
            r_elig1   <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (!bus.req0) r_elig0 <= 1'b1;
            if (!bus.req1) r_elig1 <= 1'b1;

            case (r_state)
                S_IDLE, S_RELEASE: begin
                    if (bus.ready && w_any) begin
                        r_cnt   <= '0;
                        r_owner <= w_pick1;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_state <= w_pick1 ? S_OWN1 : S_OWN0;
                    end else if (bus.ready) begin
                        r_state <= S_IDLE;
                    end
                end

                S_OWN0, S_OWN1: begin
                    if (!w_own_req) begin
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_state <= S_RELEASE;
                    end else if (w_expire) begin
                        // Revoked client must drop req before it may compete again
                        r_gnt0    <= 1'b0;
                        r_gnt1    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RELEASE;
                        if (r_state == S_OWN0) r_elig0 <= 1'b0;
                        else                   r_elig1 <= 1'b0;
                    end else if (w_act) begin
                        r_cnt <= '0;
                    end else if (C_WD_EN) begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end

                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.owner   = r_owner;
    assign bus.timeout = r_timeout;

    // Mux straight off the registered grants: no added handshake latency
    assign bus.start    = (r_gnt0 & bus.start0)   | (r_gnt1 & bus.start1);
    assign bus.send     = (r_gnt0 & bus.send0)    | (r_gnt1 & bus.send1);
    assign bus.receive  = (r_gnt0 & bus.receive0) | (r_gnt1 & bus.receive1);
    assign bus.datasend = r_gnt0 ? bus.datasend0 : (r_gnt1 ? bus.datasend1 : 8'h00);

    assign bus.ready0       = r_gnt0 & bus.ready;
    assign bus.ready1       = r_gnt1 & bus.ready;
    assign bus.sended0      = r_gnt0 & bus.sended;
    assign bus.sended1      = r_gnt1 & bus.sended;
    assign bus.received0    = r_gnt0 & bus.received;
    assign bus.received1    = r_gnt1 & bus.received;
    assign bus.datareceive0 = r_gnt0 ? bus.datareceive : 8'h00;
    assign bus.datareceive1 = r_gnt1 ? bus.datareceive : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
// ============================================================================
// Module      : tb_i2c_bus_arbiter
// Description : Directed self-checking bench for i2c_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_bus_arbiter;

    localparam int TIMEOUT = 8;
    localparam int TW      = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_arbiter_if bus();

    i2c_bus_arbiter #(
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare(input logic [31:0] obs);
        string       tag;
        logic [31:0] e_val;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
            return;
        end
        tag   = tag_q.pop_front();
        e_val = exp_q.pop_front();
        assert (obs === e_val) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e_val);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit observed=expired expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        {bus.req0, bus.req1, bus.start0, bus.start1, bus.send0, bus.send1} = '0;
        {bus.receive0, bus.receive1, bus.ready, bus.sended, bus.received}  = '0;
        bus.datasend0   = 8'h00;
        bus.datasend1   = 8'h00;
        bus.datareceive = 8'h00;

        // Reset state
        expect_val("rst_gnt0", 0); expect_val("rst_gnt1", 0); expect_val("rst_owner", 1);
        expect_val("rst_timeout", 0); expect_val("rst_start", 0); expect_val("rst_datasend", 0);
        repeat (2) @(negedge clk);
        compare(bus.gnt0); compare(bus.gnt1); compare(bus.owner);
        compare(bus.timeout); compare(bus.start); compare(bus.datasend);
        reset = 1'b1;
        bus.ready = 1'b1;
        @(negedge clk);

        // Single client grant and data path
        bus.req0 = 1'b1;
        expect_val("t1_gnt0", 1); expect_val("t1_gnt1", 0); expect_val("t1_owner", 0);
        @(negedge clk);
        compare(bus.gnt0); compare(bus.gnt1); compare(bus.owner);
        bus.datasend0 = 8'hEE;
        bus.send0     = 1'b1;
        expect_val("t1_send", 1); expect_val("t1_datasend", 8'hEE);
        #1;
        compare(bus.send); compare(bus.datasend);
        bus.send0  = 1'b0;
        bus.sended = 1'b1;
        expect_val("t1_sended0", 1); expect_val("t1_sended1", 0);
        expect_val("t1_ready0", 1);  expect_val("t1_ready1", 0);
        #1;
        compare(bus.sended0); compare(bus.sended1); compare(bus.ready0); compare(bus.ready1);
        bus.sended = 1'b0;
        bus.req0   = 1'b0;
        expect_val("t1_release_gnt0", 0);
        @(negedge clk);
        compare(bus.gnt0);
        @(negedge clk);

        // Fresh reset so client 0 wins the first contention
        reset = 1'b0;
        expect_val("t2_owner_after_reset", 1);
        @(negedge clk);
        compare(bus.owner);
        reset = 1'b1;

        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        expect_val("t2_gnt0", 1); expect_val("t2_gnt1", 0);
        @(negedge clk);
        compare(bus.gnt0); compare(bus.gnt1);
        bus.req0 = 1'b0;
        expect_val("t2_rel_gnt0", 0); expect_val("t2_rel_gnt1", 0);
        @(negedge clk);
        compare(bus.gnt0); compare(bus.gnt1);
        expect_val("t2_gnt1_next", 1); expect_val("t2_owner1", 1);
        @(negedge clk);
        compare(bus.gnt1); compare(bus.owner);
        bus.req0 = 1'b1;
        repeat (3) @(negedge clk);
        expect_val("t2_hold_gnt1", 1); expect_val("t2_hold_gnt0", 0);
        compare(bus.gnt1); compare(bus.gnt0);

        // Busy master keeps the arbiter in release
        bus.ready = 1'b0;
        bus.req1  = 1'b0;
        expect_val("t3_drop_gnt1", 0);
        @(negedge clk);
        compare(bus.gnt1);
        for (int i = 0; i < 10; i++) begin
            expect_val("t3_busy_gnt0", 0); expect_val("t3_busy_gnt1", 0);
            @(negedge clk);
            compare(bus.gnt0); compare(bus.gnt1);
        end
        bus.ready = 1'b1;
        expect_val("t3_gnt0", 1); expect_val("t3_owner0", 0);
        @(negedge clk);
        compare(bus.gnt0); compare(bus.owner);

        // Isolation of the non-owner
        bus.datasend0   = 8'h12;
        bus.datasend1   = 8'h55;
        bus.start1      = 1'b1;
        bus.send1       = 1'b1;
        bus.datareceive = 8'hA5;
        expect_val("t4_start", 0); expect_val("t4_send", 0); expect_val("t4_datasend", 8'h12);
        expect_val("t4_datareceive1", 0); expect_val("t4_datareceive0", 8'hA5);
        #1;
        compare(bus.start); compare(bus.send); compare(bus.datasend);
        compare(bus.datareceive1); compare(bus.datareceive0);
        bus.start1 = 1'b0;
        bus.send1  = 1'b0;

        // Watchdog: gnt0 held for TIMEOUT cycles, then revoked
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            expect_val("t5_hold_gnt0", 1); expect_val("t5_hold_timeout", 0);
            @(negedge clk);
            compare(bus.gnt0); compare(bus.timeout);
        end
        expect_val("t5_revoke_gnt0", 0); expect_val("t5_timeout_pulse", 1);
        @(negedge clk);
        compare(bus.gnt0); compare(bus.timeout);
        expect_val("t5_timeout_end", 0); expect_val("t5_no_regrant", 0);
        @(negedge clk);
        compare(bus.timeout); compare(bus.gnt0);
        repeat (3) @(negedge clk);
        expect_val("t5_still_no_regrant", 0);
        compare(bus.gnt0);
        bus.req0 = 1'b0;
        @(negedge clk);
        bus.req0 = 1'b1;
        expect_val("t5_regrant", 1);
        @(negedge clk);
        compare(bus.gnt0);

        // Asynchronous reset while client 1 owns the bus
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        @(negedge clk);
        expect_val("t6_gnt1", 1);
        @(negedge clk);
        compare(bus.gnt1);
        bus.start1   = 1'b1;
        bus.send1    = 1'b1;
        bus.receive1 = 1'b1;
        expect_val("t6_start_pre", 1);
        #1;
        compare(bus.start);
        #2;
        reset = 1'b0;
        expect_val("t6_rst_gnt1", 0); expect_val("t6_rst_start", 0); expect_val("t6_rst_send", 0);
        expect_val("t6_rst_receive", 0); expect_val("t6_rst_owner", 1);
        #1;
        compare(bus.gnt1); compare(bus.start); compare(bus.send);
        compare(bus.receive); compare(bus.owner);
        bus.start1   = 1'b0;
        bus.send1    = 1'b0;
        bus.receive1 = 1'b0;
        bus.req0     = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        expect_val("t6_post_gnt0", 1); expect_val("t6_post_gnt1", 0);
        @(negedge clk);
        compare(bus.gnt0); compare(bus.gnt1);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
